instr_fetch: RTL and testbench

//  Fetch stage that consumes the 7-bit program_counter output and reads instruction memory.

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_if_buf.sv | 141 ++++++++++++++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared definitions for the instruction fetch stage: default address and
//   instruction widths, and the fetch FSM state encoding.
//   Optional feature macro used by this slice: FETCH_SKID_EN (see if_buf).
// ----------------------------------------------------------------------------
package instr_fetch_pkg;

  localparam int IF_AW = 7;   // instruction address width (program_counter width)
  localparam int IF_IW = 32;  // instruction word width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if_buf.sv
// ----------------------------------------------------------------------------
// instr_fetch_if_buf
//   IF/ID output register with an optional one-entry skid buffer.
//   Macro FETCH_SKID_EN: when defined, a response that arrives while the
//   output register is full and stalled is parked in the skid entry and moves
//   into the output register when it drains. When undefined there is no skid
//   and new space only appears when the output register empties or drains.
// Ports
//   clk        in   clock, posedge
//   reset      in   asynchronous, active-low
//   flush      in   discard the output register and the skid entry
//   wr_en      in   accept a fetched word (caller guarantees space)
//   wr_instr   in   fetched word
//   wr_pc      in   address of the fetched word
//   id_ready   in   decode accepts the output register this cycle
//   space      out  a new request may be issued now
//   out_valid  out  output register holds a word for decode
//   out_instr  out  output register word
//   out_pc     out  output register address
// ----------------------------------------------------------------------------
module instr_fetch_if_buf
  import instr_fetch_pkg::*;
#(
  parameter int AW = IF_AW,
  parameter int IW = IF_IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_instr,
  input  logic [AW-1:0] wr_pc,
  input  logic          id_ready,
  output logic          space,
  output logic          out_valid,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc
);

  logic          valid_q, valid_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          drain;

  assign drain     = valid_q & id_ready;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

`ifdef FETCH_SKID_EN
  logic          skid_valid_q, skid_valid_d;
  logic [IW-1:0] skid_instr_q, skid_instr_d;
  logic [AW-1:0] skid_pc_q, skid_pc_d;

  // With one request outstanding at most, an empty skid is always enough
  // room for the next response even if decode stays stalled.
  assign space = ~skid_valid_q | drain;

  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (drain) begin
        if (skid_valid_q) begin
          valid_d      = 1'b1;
          instr_d      = skid_instr_q;
          pc_d         = skid_pc_q;
          skid_valid_d = 1'b0;
        end else begin
          valid_d = 1'b0;
        end
      end
      // A response lands in the output register if it is free after this
      // cycle's drain/refill, otherwise it is parked in the skid entry.
      if (wr_en) begin
        if (!valid_d) begin
          valid_d = 1'b1;
          instr_d = wr_instr;
          pc_d    = wr_pc;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = wr_instr;
          skid_pc_d    = wr_pc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end
`else
  assign space = ~valid_q | drain;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else begin
      if (drain) begin
        valid_d = 1'b0;
      end
      if (wr_en) begin
        valid_d = 1'b1;
        instr_d = wr_instr;
        pc_d    = wr_pc;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage between program_counter and decode. Samples pc_in, issues one
//   instruction memory read at a time, and hands the returned word to decode
//   through the IF/ID register in instr_fetch_if_buf. Produces the sequential
//   next PC (pc_seq) and a one-cycle pc_adv strobe when a fetch is granted.
//   Macro FETCH_SKID_EN enables a one-entry skid buffer in the IF/ID stage.
// Ports
//   clk         in   clock, posedge
//   reset       in   asynchronous, active-low; clears all state immediately
//   pc_in       in   current PC from program_counter
//   flush       in   branch/jump taken: discard in-flight and buffered words
//   mem_req     out  memory read request
//   mem_addr    out  read address, stable while waiting for mem_gnt
//   mem_gnt     in   request accepted this cycle
//   mem_rvalid  in   read data valid (at least one cycle after grant)
//   mem_rdata   in   instruction word
//   if_valid    out  if_instr/if_pc valid for decode
//   if_instr    out  fetched instruction
//   if_pc       out  address of if_instr
//   id_ready    in   decode accepts when if_valid & id_ready
//   pc_seq      out  req_pc + 1 (wraps), sequential next PC
//   pc_adv      out  one-cycle pulse: sequential PC may advance
// ----------------------------------------------------------------------------
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int AW = IF_AW,
  parameter int IW = IF_IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [IW-1:0] mem_rdata,
  output logic          if_valid,
  output logic [IW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          id_ready,
  output logic [AW-1:0] pc_seq,
  output logic          pc_adv
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic          drop_q, drop_d;
  logic          pc_adv_q, pc_adv_d;
  logic          buf_space;
  logic          rsp_accept;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    pc_adv_d   = 1'b0;
    rsp_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (buf_space && !flush) begin
          state_d  = ST_REQ;
          req_pc_d = pc_in;
        end
      end
      ST_REQ: begin
        // A request is never withdrawn; a flush only marks its response stale.
        if (flush) drop_d = 1'b1;
        if (mem_gnt) begin
          state_d = ST_WAIT;
          // A flush in the grant cycle redirects the PC, so do not advance it.
          pc_adv_d = ~drop_q & ~flush;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d    = ST_IDLE;
          drop_d     = 1'b0;
          rsp_accept = ~drop_q & ~flush;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
      pc_adv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      pc_adv_q <= pc_adv_d;
    end
  end

  assign mem_req  = (state_q == ST_REQ);
  assign mem_addr = req_pc_q;
  assign pc_seq   = req_pc_q + AW'(1);
  assign pc_adv   = pc_adv_q;

  instr_fetch_if_buf #(
    .AW(AW),
    .IW(IW)
  ) u_if_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_en    (rsp_accept),
    .wr_instr (mem_rdata),
    .wr_pc    (req_pc_q),
    .id_ready (id_ready),
    .space    (buf_space),
    .out_valid(if_valid),
    .out_instr(if_instr),
    .out_pc   (if_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A memory responder grants requests from a
//   grant budget and returns data one cycle later (optionally held back), and
//   a program_counter stand-in advances pc_in on pc_adv. Expected IF/ID words
//   are queued by the directed steps and checked when decode takes them.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int AW = IF_AW;
  localparam int IW = IF_IW;
`ifdef FETCH_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic          flush = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic          if_valid;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          id_ready = 1'b1;
  logic [AW-1:0] pc_seq;
  logic          pc_adv;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .id_ready  (id_ready),
    .pc_seq    (pc_seq),
    .pc_adv    (pc_adv)
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] seq_log[$];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            gnt_budget = 0;
  int            gnt_count = 0;
  int            adv_count = 0;
  int            req_cycles = 0;
  bit            hold_rv = 1'b0;
  bit            ovr_en = 1'b0;
  bit            rv_pend = 1'b0;
  logic [AW-1:0] rv_addr = '0;
  logic [AW-1:0] jump_val = '0;
  bit            jump_tog = 1'b0;
  bit            jump_seen = 1'b0;

  function automatic logic [IW-1:0] word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | IW'(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the values that the coming posedge will act on, then at
  // the negedge play memory and program_counter for the next posedge.
  task automatic tick();
    exp_t e;
    if (if_valid && id_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("xfer_pc", 64'(if_pc), 64'(e.pc));
        check("xfer_instr", 64'(if_instr), 64'(e.instr));
      end
      $display("[TB] xfer pc=%0d instr=%08h", if_pc, if_instr);
    end
    if (pc_adv) begin
      adv_count++;
      seq_log.push_back(pc_seq);
    end
    if (mem_req) req_cycles++;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    if (jump_tog != jump_seen) begin
      pc_in     = jump_val;
      jump_seen = jump_tog;
    end else if (pc_adv) begin
      pc_in = pc_seq;
    end
    if (!reset) begin
      rv_pend = 1'b0;
    end else if (rv_pend && !hold_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = ovr_en ? 32'hDEAD_BEEF : word(rv_addr);
      rv_pend    = 1'b0;
    end else if (mem_req && gnt_budget > 0) begin
      mem_gnt = 1'b1;
      gnt_budget--;
      gnt_count++;
      rv_pend = 1'b1;
      rv_addr = mem_addr;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    tick();
  endtask

  task automatic wait_grant(input string tag);
    int gsnap;
    gsnap = gnt_count;
    for (int n = 0; n < 30; n++) begin
      if (gnt_count != gsnap) break;
      tick();
    end
    check({tag, "_granted"}, 64'(gnt_count - gsnap), 64'd1);
  endtask

  initial begin
    int adv_snap;
    int gsnap;
    logic [AW-1:0] a_pc;

    // ---- reset values ----
    repeat (3) tick();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);
    check("rst_if_pc", 64'(if_pc), 64'd0);
    check("rst_pc_adv", 64'(pc_adv), 64'd0);
    check("rst_pc_seq", 64'(pc_seq), 64'd1);

    // ---- 1: back-to-back fetch of 0,1,2 ----
    for (int i = 0; i < 3; i++) sb.push_back('{pc: AW'(i), instr: word(AW'(i))});
    gnt_budget = 3;
    reset = 1'b1;
    wait_drain("t1");
    tick();
    check("t1_adv_count", 64'(adv_count), 64'd3);
    check("t1_seq0", 64'(seq_log[0]), 64'd1);
    check("t1_seq1", 64'(seq_log[1]), 64'd2);
    check("t1_seq2", 64'(seq_log[2]), 64'd3);

    // ---- 2: grant withheld for 4 cycles ----
    adv_snap = adv_count;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_mem_req", 64'(mem_req), 64'd1);
      check("t2_mem_addr", 64'(mem_addr), 64'd3);
    end
    check("t2_no_adv", 64'(adv_count), 64'(adv_snap));
    sb.push_back('{pc: AW'(3), instr: word(AW'(3))});
    gnt_budget = 1;
    wait_drain("t2");
    check("t2_adv_after", 64'(adv_count), 64'(adv_snap + 1));

    // ---- 3: decode stall ----
    id_ready = 1'b0;
    sb.push_back('{pc: AW'(4), instr: word(AW'(4))});
    gnt_budget = 1;
    for (int n = 0; n < 20; n++) begin
      if (if_valid) break;
      tick();
    end
    check("t3_valid", 64'(if_valid), 64'd1);
    gsnap = gnt_count;
    gnt_budget = SKID ? 1 : 0;
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_if_pc", 64'(if_pc), 64'd4);
      check("t3_if_instr", 64'(if_instr), 64'(word(AW'(4))));
    end
    check("t3_grants", 64'(gnt_count - gsnap), 64'(SKID ? 1 : 0));
    check("t3_req_cycles", 64'(req_cycles), 64'(SKID ? 1 : 0));
    if (SKID) sb.push_back('{pc: AW'(5), instr: word(AW'(5))});
    id_ready = 1'b1;
    tick();
    tick();
    check("t3_nogap_valid", 64'(if_valid), 64'(SKID));
    wait_drain("t3");

    // ---- 4: flush in WAIT with same-cycle rvalid ----
    a_pc = SKID ? AW'(6) : AW'(5);
    repeat (2) tick();
    check("t4_req", 64'(mem_req), 64'd1);
    check("t4_addr", 64'(mem_addr), 64'(a_pc));
    hold_rv = 1'b1;
    ovr_en  = 1'b1;
    gnt_budget = 1;
    wait_grant("t4");
    tick();
    hold_rv  = 1'b0;
    jump_val = AW'(100);
    jump_tog = ~jump_tog;
    tick();
    adv_snap = adv_count;
    flush = 1'b1;
    gnt_budget = 1;
    sb.push_back('{pc: AW'(100), instr: word(AW'(100))});
    tick();
    flush  = 1'b0;
    ovr_en = 1'b0;
    check("t4_flush_valid", 64'(if_valid), 64'd0);
    check("t4_no_adv", 64'(adv_count), 64'(adv_snap));
    wait_drain("t4");
    check("t4_adv_refetch", 64'(adv_count), 64'(adv_snap + 1));
    check("t4_seq", 64'(seq_log[seq_log.size()-1]), 64'd101);

    // ---- 5: flush in REQ, then wrap at 127 ----
    repeat (2) tick();
    jump_val = AW'(127);
    jump_tog = ~jump_tog;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    adv_snap = adv_count;
    gnt_budget = 2;
    sb.push_back('{pc: AW'(127), instr: word(AW'(127))});
    wait_drain("t5");
    check("t5_adv", 64'(adv_count), 64'(adv_snap + 1));
    check("t5_pc_seq_wrap", 64'(seq_log[seq_log.size()-1]), 64'd0);

    // ---- 6: asynchronous reset while in WAIT ----
    tick();
    check("t6_req", 64'(mem_req), 64'd1);
    hold_rv = 1'b1;
    gnt_budget = 1;
    wait_grant("t6");
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("t6_mem_req", 64'(mem_req), 64'd0);
    check("t6_mem_addr", 64'(mem_addr), 64'd0);
    check("t6_if_valid", 64'(if_valid), 64'd0);
    check("t6_if_instr", 64'(if_instr), 64'd0);
    check("t6_if_pc", 64'(if_pc), 64'd0);
    check("t6_pc_adv", 64'(pc_adv), 64'd0);
    hold_rv  = 1'b0;
    jump_val = AW'(55);
    jump_tog = ~jump_tog;
    tick();
    tick();
    sb.push_back('{pc: AW'(55), instr: word(AW'(55))});
    gnt_budget = 1;
    reset = 1'b1;
    wait_drain("t6");
    check("t6_first_addr", 64'(rv_addr), 64'd55);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
